// File: rtl/commit_watchdog.sv
// Commit-progress watchdog: live cycle/instruction counters, sticky stuck detection and periodic
// snapshot reports. Define COMMIT_WATCHDOG_MAX_STALL_EN to track the longest no-commit run.
module commit_watchdog #(
  parameter int unsigned COMMIT_WIDTH    = 6,
  parameter int unsigned CNT_WIDTH       = 64,
  parameter int unsigned STALL_LIMIT     = 2000,
  parameter int unsigned REPORT_INTERVAL = 10000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    clear,
  input  logic [COMMIT_WIDTH-1:0] commit_valid,
  input  logic                    commit_is_walk,
  output logic [CNT_WIDTH-1:0]    cycle_count,
  output logic [CNT_WIDTH-1:0]    instr_count,
  output logic                    stuck,
  output logic                    report_valid,
  input  logic                    report_ready,
  output logic [CNT_WIDTH-1:0]    report_cycle,
  output logic [CNT_WIDTH-1:0]    report_instr,
  output logic [15:0]             report_overrun,
  output logic [31:0]             max_stall
);

  localparam int unsigned PopW = $clog2(COMMIT_WIDTH + 1);
  localparam int unsigned IntW = $clog2(REPORT_INTERVAL);
  localparam logic [IntW-1:0] IntLast = IntW'(REPORT_INTERVAL - 1);

  typedef enum logic [1:0] {StIdle, StRun, StStuck} state_e;

  state_e state_q, state_d;

  logic [CNT_WIDTH-1:0] cycle_q, cycle_d, instr_q, instr_d;
  logic [CNT_WIDTH-1:0] rcycle_q, rcycle_d, rinstr_q, rinstr_d;
  logic [31:0]          stall_q, stall_d;
  logic [IntW-1:0]      interval_q, interval_d;
  logic [15:0]          overrun_q, overrun_d;
  logic                 rvalid_q, rvalid_d;

  logic [PopW-1:0] commit_pop;
  logic            has_commit, run_active, active, due, load;

  always_comb begin
    commit_pop = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      commit_pop = commit_pop + PopW'(commit_valid[i]);
    end
  end

  assign has_commit = !commit_is_walk && (commit_valid != '0);
  // Counting happens in RUN while still enabled, and unconditionally once stuck.
  assign run_active = (state_q == StRun) && enable;
  assign active     = run_active || (state_q == StStuck);
  assign due        = run_active && (interval_q == IntLast);
  assign load       = due && (!rvalid_q || report_ready);

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  if (enable) state_d = StRun;
        StRun: begin
          if (!enable) begin
            state_d = StIdle;
          end else if (stall_q > 32'(STALL_LIMIT)) begin
            state_d = StStuck;
          end
        end
        StStuck: state_d = StStuck;
        default: state_d = StIdle;
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    stuck = (state_q == StStuck);
  end

  always_comb begin
    cycle_d    = cycle_q;
    instr_d    = instr_q;
    stall_d    = stall_q;
    interval_d = interval_q;
    rcycle_d   = rcycle_q;
    rinstr_d   = rinstr_q;
    rvalid_d   = rvalid_q;
    overrun_d  = overrun_q;
    if (clear) begin
      cycle_d    = '0;
      instr_d    = '0;
      stall_d    = '0;
      interval_d = '0;
      rcycle_d   = '0;
      rinstr_d   = '0;
      rvalid_d   = 1'b0;
      overrun_d  = '0;
    end else begin
      if (active) begin
        cycle_d = cycle_q + 1'b1;
        if (!commit_is_walk) begin
          instr_d = instr_q + CNT_WIDTH'(commit_pop);
        end
        if (has_commit) begin
          stall_d = '0;
        end else if (stall_q != '1) begin
          stall_d = stall_q + 1'b1;
        end
      end
      if (run_active) begin
        interval_d = due ? '0 : interval_q + 1'b1;
      end
      // A snapshot due against a stalled consumer is dropped; the offered one stays intact.
      if (load) begin
        rcycle_d = cycle_q;
        rinstr_d = instr_q;
        rvalid_d = 1'b1;
      end else if (rvalid_q && report_ready) begin
        rvalid_d = 1'b0;
      end
      if (due && !load && (overrun_q != 16'hFFFF)) begin
        overrun_d = overrun_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cycle_q    <= '0;
      instr_q    <= '0;
      stall_q    <= '0;
      interval_q <= '0;
      rcycle_q   <= '0;
      rinstr_q   <= '0;
      rvalid_q   <= 1'b0;
      overrun_q  <= '0;
    end else begin
      cycle_q    <= cycle_d;
      instr_q    <= instr_d;
      stall_q    <= stall_d;
      interval_q <= interval_d;
      rcycle_q   <= rcycle_d;
      rinstr_q   <= rinstr_d;
      rvalid_q   <= rvalid_d;
      overrun_q  <= overrun_d;
    end
  end

`ifdef COMMIT_WATCHDOG_MAX_STALL_EN
  logic [31:0] max_stall_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      max_stall_q <= '0;
    end else if (clear) begin
      max_stall_q <= '0;
    end else if (active && (stall_q > max_stall_q)) begin
      max_stall_q <= stall_q;
    end
  end

  assign max_stall = max_stall_q;
`else
  assign max_stall = '0;
`endif

  assign cycle_count    = cycle_q;
  assign instr_count    = instr_q;
  assign report_valid   = rvalid_q;
  assign report_cycle   = rcycle_q;
  assign report_instr   = rinstr_q;
  assign report_overrun = overrun_q;

endmodule

// File: tb/tb_commit_watchdog.sv
// Self-checking bench for commit_watchdog: directed scenarios plus randomized traffic, all
// outputs compared every cycle against a behavioural model of the watchdog rules.
module tb_commit_watchdog;

  localparam int unsigned CW = 6;
  localparam int unsigned NW = 16;
  localparam int unsigned SL = 5;
  localparam int unsigned RI = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          clear = 1'b0;
  logic [CW-1:0] commit_valid = '0;
  logic          commit_is_walk = 1'b0;
  logic          report_ready = 1'b0;
  logic [NW-1:0] cycle_count, instr_count, report_cycle, report_instr;
  logic          stuck, report_valid;
  logic [15:0]   report_overrun;
  logic [31:0]   max_stall;

  int checks = 0;
  int failures = 0;

  commit_watchdog #(
    .COMMIT_WIDTH    (CW),
    .CNT_WIDTH       (NW),
    .STALL_LIMIT     (SL),
    .REPORT_INTERVAL (RI)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .enable         (enable),
    .clear          (clear),
    .commit_valid   (commit_valid),
    .commit_is_walk (commit_is_walk),
    .cycle_count    (cycle_count),
    .instr_count    (instr_count),
    .stuck          (stuck),
    .report_valid   (report_valid),
    .report_ready   (report_ready),
    .report_cycle   (report_cycle),
    .report_instr   (report_instr),
    .report_overrun (report_overrun),
    .max_stall      (max_stall)
  );

  always #5 clock = ~clock;

  // Behavioural model: armed/stuck flags, counted-cycle tally and snapshot slot.
  bit          m_run, m_stuck, m_rv;
  logic [15:0] m_cyc, m_instr, m_rc, m_ri, m_ov;
  int unsigned m_stall, m_max, m_runcnt;

  task automatic model_reset();
    m_run = 0; m_stuck = 0; m_rv = 0;
    m_cyc = '0; m_instr = '0; m_rc = '0; m_ri = '0; m_ov = '0;
    m_stall = 0; m_max = 0; m_runcnt = 0;
  endtask

  task automatic model_update();
    bit          counting_run, active, has, due;
    int unsigned old_stall;
    if (clear) begin
      model_reset();
      return;
    end
    old_stall    = m_stall;
    counting_run = m_run && enable;
    active       = counting_run || m_stuck;
    has          = !commit_is_walk && (commit_valid != 0);
    due          = counting_run && ((m_runcnt % RI) == RI - 1);
    if (due) begin
      if (!m_rv || report_ready) begin
        m_rc = m_cyc;
        m_ri = m_instr;
        m_rv = 1;
      end else if (m_ov != 16'hFFFF) begin
        m_ov = m_ov + 1;
      end
    end else if (m_rv && report_ready) begin
      m_rv = 0;
    end
    if (active) begin
      if (old_stall > m_max) m_max = old_stall;
      m_cyc = m_cyc + 1;
      if (!commit_is_walk) m_instr = m_instr + 16'($countones(commit_valid));
      if (has) m_stall = 0;
      else if (m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
    end
    if (counting_run) m_runcnt++;
    if (!m_stuck) begin
      if (m_run) begin
        if (!enable) m_run = 0;
        else if (old_stall > SL) begin
          m_run = 0;
          m_stuck = 1;
        end
      end else if (enable) begin
        m_run = 1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    logic [31:0] exp_max;
`ifdef COMMIT_WATCHDOG_MAX_STALL_EN
    exp_max = m_max;
`else
    exp_max = 32'd0;
`endif
    chk("cycle_count", 64'(cycle_count), 64'(m_cyc));
    chk("instr_count", 64'(instr_count), 64'(m_instr));
    chk("stuck", 64'(stuck), 64'(m_stuck));
    chk("report_valid", 64'(report_valid), 64'(m_rv));
    chk("report_cycle", 64'(report_cycle), 64'(m_rc));
    chk("report_instr", 64'(report_instr), 64'(m_ri));
    chk("report_overrun", 64'(report_overrun), 64'(m_ov));
    chk("max_stall", 64'(max_stall), 64'(exp_max));
  endtask

  task automatic step();
    @(posedge clock);
    model_update();
    #1;
    compare_all();
  endtask

  task automatic drive(input bit en, input bit clr, input logic [CW-1:0] cv, input bit walk,
                       input bit rdy);
    enable = en; clear = clr; commit_valid = cv; commit_is_walk = walk; report_ready = rdy;
  endtask

  task automatic restart(input bit rdy);
    drive(1, 1, '0, 0, rdy);
    step();
    drive(1, 0, '0, 0, rdy);
    step();
  endtask

  initial begin
    logic [NW-1:0] seen[$];
    model_reset();
    #12;
    compare_all();
    reset = 1'b0;

    // Main counting: 3 commits per cycle for 10 cycles.
    restart(1);
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 6'b000111, 0, 1);
      step();
    end
    chk("a_cycle10", 64'(cycle_count), 64'd10);
    chk("a_instr30", 64'(instr_count), 64'd30);

    // Walk slots do not count as commits.
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 6'b111111, 1, 1);
      step();
    end
    chk("b_instr_walk", 64'(instr_count), 64'd30);
    chk("b_not_stuck", 64'(stuck), 64'd0);

    // Stuck rises exactly 7 edges after the last commit edge.
    restart(1);
    drive(1, 0, 6'b100000, 0, 1);
    step();
    for (int k = 1; k <= 7; k++) begin
      drive(1, 0, '0, 0, 1);
      step();
      chk("c_stuck_timing", 64'(stuck), 64'(k == 7));
    end
    drive(0, 1, '0, 0, 1);
    step();
    chk("c_clear_stuck", 64'(stuck), 64'd0);
    chk("c_clear_cycle", 64'(cycle_count), 64'd0);

    // Snapshots every 4 counted cycles with a ready consumer.
    restart(1);
    for (int i = 0; i < 12; i++) begin
      drive(1, 0, CW'($urandom), 0, 1);
      step();
      if (report_valid) seen.push_back(report_cycle);
    end
    chk("d_snap_count", 64'(seen.size()), 64'd3);
    for (int i = 0; i < seen.size() && i < 3; i++) chk("d_snap_cycle", 64'(seen[i]), 64'(4 * i + 3));

    // Stalled consumer: two dropped snapshots, then transfer and a fresh one at 15.
    restart(0);
    for (int i = 0; i < 12; i++) begin
      drive(1, 0, 6'b000001, 0, 0);
      step();
    end
    chk("e_held_cycle", 64'(report_cycle), 64'd3);
    chk("e_overrun", 64'(report_overrun), 64'd2);
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 6'b000001, 0, 1);
      step();
    end
    chk("e_next_valid", 64'(report_valid), 64'd1);
    chk("e_next_cycle", 64'(report_cycle), 64'd15);

    // Stall runs of 3, 9 and 4 cycles.
    restart(1);
    drive(1, 0, 6'b000010, 0, 1); step();
    for (int i = 0; i < 3; i++) begin drive(1, 0, '0, 0, 1); step(); end
    drive(1, 0, 6'b000010, 0, 1); step();
    for (int i = 0; i < 9; i++) begin drive(1, 0, '0, 0, 1); step(); end
    drive(1, 0, 6'b000010, 0, 1); step();
    for (int i = 0; i < 4; i++) begin drive(1, 0, '0, 0, 1); step(); end
    drive(1, 0, 6'b000010, 0, 1); step();
`ifdef COMMIT_WATCHDOG_MAX_STALL_EN
    chk("g_max_stall", 64'(max_stall), 64'd9);
`else
    chk("g_max_stall", 64'(max_stall), 64'd0);
`endif

    // Randomized traffic.
    restart(1);
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 10) != 0, ($urandom % 60) == 0,
            (($urandom % 3) == 0) ? CW'($urandom) : '0,
            ($urandom % 5) == 0, $urandom % 2);
      step();
    end

    // Asynchronous reset mid-run and mid-handshake.
    restart(0);
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, 6'b000011, 0, 0);
      step();
    end
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    #1;
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, 6'b000011, 0, 1);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
